// File: rtl/pdm_modulator.sv
// First-order delta-sigma PDM modulator for the mono audio output pin.
// PCM enters through a one-deep holding buffer and is swapped in at each sample-period boundary.
module pdm_modulator #(
  parameter int CLK_DIV = 32,
  parameter int OSR     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        mute_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        fs_o,
  output logic        underrun_o,
  input  logic        clr_underrun_i,
  output logic        pdm_data_o,
  output logic        pdm_en_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TCK_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [TCK_W-1:0] TCK_MAX = TCK_W'(OSR - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [TCK_W-1:0] r_tick_cnt;
  logic [15:0]      r_acc;
  logic [15:0]      r_cur;
  logic [15:0]      r_buf;
  logic             r_buf_full;
  logic             r_fs;
  logic             r_underrun;
  logic             r_pdm;
  logic             r_pdm_en;

  logic             w_mod_tick;
  logic             w_boundary;
  logic             w_accept;
  logic [15:0]      w_u;
  logic [16:0]      w_acc17;

  assign w_mod_tick = enable_i && (r_div_cnt == DIV_MAX);
  assign w_boundary = w_mod_tick && (r_tick_cnt == TCK_MAX);
  assign sample_ready_o = !r_buf_full && !rst_i;
  assign w_accept   = sample_valid_i && sample_ready_o;

  // Signed PCM to offset binary so midscale (PCM 0) gives 50% density.
  assign w_u     = mute_i ? 16'h8000 : (r_cur ^ 16'h8000);
  assign w_acc17 = {1'b0, r_acc} + {1'b0, w_u};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_acc      <= '0;
      r_cur      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_fs       <= 1'b0;
      r_underrun <= 1'b0;
      r_pdm      <= 1'b0;
      r_pdm_en   <= 1'b0;
    end else begin
      if (enable_i)
        r_div_cnt <= (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + 1'b1;

      if (w_mod_tick) begin
        r_tick_cnt <= (r_tick_cnt == TCK_MAX) ? '0 : r_tick_cnt + 1'b1;
        r_acc      <= w_acc17[15:0];
        r_pdm      <= w_acc17[16];
      end
      if (!enable_i)
        r_pdm <= 1'b0;

      r_fs     <= w_boundary;
      r_pdm_en <= enable_i;

      // A full buffer forces ready low, so a swap and an accept never collide.
      if (w_boundary && r_buf_full) begin
        r_cur      <= r_buf;
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf      <= sample_i;
        r_buf_full <= 1'b1;
      end

      if (w_boundary && !r_buf_full)
        r_underrun <= 1'b1;
      else if (clr_underrun_i)
        r_underrun <= 1'b0;
    end
  end

  assign fs_o       = r_fs;
  assign underrun_o = r_underrun;
  assign pdm_data_o = r_pdm;
  assign pdm_en_o   = r_pdm_en;

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: reference model over an enabled-cycle count, density table, corner sequences, random run.
module tb_pdm_modulator;
  localparam int CLK_DIV = 4;
  localparam int OSR     = 8;
  localparam int PER     = CLK_DIV * OSR;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        mute_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic        fs_o;
  logic        underrun_o;
  logic        clr_underrun_i = 1'b0;
  logic        pdm_data_o;
  logic        pdm_en_o;

  pdm_modulator #(.CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mute_i(mute_i),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .fs_o(fs_o), .underrun_o(underrun_o), .clr_underrun_i(clr_underrun_i),
    .pdm_data_o(pdm_data_o), .pdm_en_o(pdm_en_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: time is the number of enabled cycles since reset,
  // the accumulator is an integer modulo 65536, the buffer a 0/1-entry slot.
  int          m_n = 0;
  int          m_acc = 0;
  int          m_ticks = 0;
  int          m_tickidx = 0;
  logic [15:0] m_cur = '0;
  logic [15:0] m_buf = '0;
  bit          m_full = 0, m_pdm = 0, m_en = 0, m_fs = 0, m_und = 0, m_tick = 0;
  int          m_u, m_s;
  bit          m_take, m_bnd;

  always @(posedge clk) begin
    m_tick = 0;
    if (rst_i) begin
      m_n = 0; m_acc = 0; m_ticks = 0; m_cur = '0; m_buf = '0;
      m_full = 0; m_pdm = 0; m_en = 0; m_fs = 0; m_und = 0;
    end else begin
      m_take = sample_valid_i && !m_full;
      m_bnd  = enable_i && (m_n % PER == PER - 1);
      if (enable_i && (m_n % CLK_DIV == CLK_DIV - 1)) begin
        m_u   = mute_i ? 32768 : int'($signed(m_cur)) + 32768;
        m_s   = m_acc + m_u;
        m_pdm = (m_s >= 65536);
        m_acc = m_s % 65536;
        m_tick = 1;
        m_tickidx = m_ticks;
        m_ticks++;
      end
      if (!enable_i) m_pdm = 0;
      m_fs = m_bnd;
      m_en = enable_i;
      if (m_bnd && !m_full) m_und = 1;
      else if (clr_underrun_i) m_und = 0;
      if (m_bnd && m_full) begin
        m_cur = m_buf;
        m_full = 0;
      end else if (m_take) begin
        m_buf = sample_i;
        m_full = 1;
      end
      if (enable_i) m_n++;
    end
  end

  bit chk_on = 0;
  bit win_on = 0;
  int win_lo = 0, win_hi = 0, ones = 0;

  always @(negedge clk) begin
    if (chk_on)
      chk("model", {27'd0, pdm_data_o, pdm_en_o, fs_o, underrun_o, sample_ready_o},
                   {27'd0, m_pdm, m_en, m_fs, m_und, (!m_full && !rst_i)});
    if (win_on && m_tick && m_tickidx >= win_lo && m_tickidx <= win_hi)
      ones += int'(pdm_data_o);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; sample_valid_i = 1'b0; clr_underrun_i = 1'b0; mute_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
  endtask

  task automatic wait_fs(output int c);
    c = 0;
    do begin
      cyc();
      c++;
    end while (!fs_o && c < 400);
  endtask

  task automatic wait_phase(input int ph);
    int g;
    g = 0;
    while ((m_n % PER) != ph && g < 400) begin
      cyc();
      g++;
    end
    if (g >= 400) chk("wait_phase_timeout", 0, 1);
  endtask

  typedef struct {
    logic [15:0] s;
    logic        mute;
    int          exp_ones;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int c, g, k, acc_cnt;
    bit pend;

    // 32 ticks from acc=0 with constant u give floor(32*u/65536) ones.
    tbl[0] = '{16'h7FFF, 1'b0, 31};
    tbl[1] = '{16'h8000, 1'b0, 0};
    tbl[2] = '{16'h0000, 1'b0, 16};
    tbl[3] = '{16'h7FFF, 1'b1, 16};
    tbl[4] = '{16'h4000, 1'b0, 24};
    tbl[5] = '{16'hC000, 1'b0, 8};
    tbl[6] = '{16'h0001, 1'b0, 16};
    tbl[7] = '{16'hFFFF, 1'b0, 15};

    cyc(); cyc(); cyc();
    chk_on = 1;
    chk("rst_vals", {28'd0, pdm_data_o, pdm_en_o, fs_o, underrun_o}, 32'd0);
    chk("rdy_in_rst", {31'd0, sample_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rdy_after_rst", {31'd0, sample_ready_o}, 32'd1);

    // Idle run: midscale density, underrun at first boundary, fs every period.
    enable_i = 1'b1;
    wait_fs(c);
    chk("fs_first", c, PER);
    chk("underrun_first_bnd", {31'd0, underrun_o}, 32'd1);
    wait_fs(c);
    chk("fs_period", c, PER);

    // Density table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mute_i = tbl[i].mute;
      sample_i = tbl[i].s;
      sample_valid_i = 1'b1;
      enable_i = 1'b1;
      ones = 0; win_lo = 8; win_hi = 39; win_on = 1;
      g = 0;
      while (m_ticks < 41 && g < 400) begin
        cyc();
        g++;
      end
      win_on = 0;
      chk($sformatf("density_%0d", i), ones, tbl[i].exp_ones);
    end

    // Continuous valid with incrementing data: one accept per period.
    do_reset();
    k = 0;
    sample_i = 16'(k);
    sample_valid_i = 1'b1;
    enable_i = 1'b1;
    #1;
    pend = sample_ready_o;
    acc_cnt = 0;
    for (int i = 0; i < 6 * PER; i++) begin
      cyc();
      if (pend) begin
        k++;
        if (i >= 2 * PER) acc_cnt++;
      end
      sample_i = 16'(k * 16'h0111);
      #1;
      pend = sample_ready_o;
    end
    chk("accepts_per_4_periods", acc_cnt, 4);
    chk("no_underrun_streaming", {31'd0, underrun_o}, 32'd0);

    // Starve, then accept in the boundary cycle.
    sample_valid_i = 1'b0;
    wait_fs(c);
    wait_phase(PER - 1);
    sample_valid_i = 1'b1;
    sample_i = 16'h1234;
    cyc();
    sample_valid_i = 1'b0;
    chk("starve_underrun", {31'd0, underrun_o}, 32'd1);
    chk("starve_accepted", {31'd0, sample_ready_o}, 32'd0);
    chk("starve_fs", {31'd0, fs_o}, 32'd1);
    wait_fs(c);
    chk("late_sample_loaded", {31'd0, sample_ready_o}, 32'd1);
    chk("underrun_sticky", {31'd0, underrun_o}, 32'd1);
    clr_underrun_i = 1'b1;
    cyc();
    clr_underrun_i = 1'b0;
    chk("underrun_clr", {31'd0, underrun_o}, 32'd0);
    wait_phase(PER - 1);
    clr_underrun_i = 1'b1;
    cyc();
    clr_underrun_i = 1'b0;
    chk("underrun_set_wins", {31'd0, underrun_o}, 32'd1);

    // Disable mid-period; buffer still takes one sample.
    wait_phase(13);
    enable_i = 1'b0;
    sample_valid_i = 1'b1;
    sample_i = 16'h0555;
    cyc();
    sample_valid_i = 1'b0;
    chk("dis_pdm", {31'd0, pdm_data_o}, 32'd0);
    chk("dis_en", {31'd0, pdm_en_o}, 32'd0);
    chk("dis_accept", {31'd0, sample_ready_o}, 32'd0);
    repeat (10) cyc();
    enable_i = 1'b1;
    wait_fs(c);
    chk("resume_fs", c, PER - 13);
    chk("resume_en", {31'd0, pdm_en_o}, 32'd1);

    // Reset mid-period with the buffer full.
    sample_valid_i = 1'b1;
    sample_i = 16'h2222;
    cyc();
    sample_valid_i = 1'b0;
    chk("buf_full_before_rst", {31'd0, sample_ready_o}, 32'd0);
    wait_phase(16);
    rst_i = 1'b1;
    cyc();
    chk("midrst_vals", {28'd0, pdm_data_o, pdm_en_o, fs_o, underrun_o}, 32'd0);
    chk("midrst_rdy", {31'd0, sample_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("midrst_rdy_after", {31'd0, sample_ready_o}, 32'd1);

    // Random traffic against the model.
    enable_i = 1'b1;
    repeat (3000) begin
      cyc();
      rst_i = ($urandom % 600) == 0;
      if (($urandom % 64) == 0) enable_i = ~enable_i;
      if (($urandom % 50) == 0) mute_i = ~mute_i;
      sample_valid_i = ($urandom % 3) != 0;
      sample_i = 16'($urandom);
      clr_underrun_i = ($urandom % 40) == 0;
    end
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
